intr_ctrl: RTL and testbench

Interrupt controller that sits directly downstream of the button debouncer and the other one-cycle interrupt sources. It latches single-cycle source pulses into per-source pending bits and gates them with a software-writable enable mask. It presents one prioritised request at a time to the CPU core over a req/ack/eoi handshake. It also records a sticky overrun flag when a source pulses again while its previous event is still pending.

---
 rtl/intr_pkg.sv | 8 +
 rtl/intr_prio_enc.sv | 16 +
 rtl/intr_ctrl.sv | 64 ++++++
 tb/tb_intr_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// intr_pkg: shared FSM state encoding and interrupt source indices
package intr_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    localparam int SRC_BUTTON  = 0;
    localparam int SRC_TIMER   = 1;
    localparam int SRC_UART_RX = 2;
    localparam int SRC_SPARE   = 3;
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: lowest-index-wins priority encoder
module intr_prio_enc #(
    parameter int NSRC    = 4,
    parameter int CAUSE_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]    req,
    output logic [CAUSE_W-1:0] idx,
    output logic               valid
);
    always_comb begin
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            idx = req[i] ? CAUSE_W'(i) : idx;
        valid = |req;
    end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: pending/mask latch with a committed req/ack/eoi handshake
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NSRC    = 4,
    parameter int CAUSE_W = $clog2(NSRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NSRC-1:0]    src_pulse,
    input  logic               mask_we,
    input  logic [NSRC-1:0]    mask_wdata,
    output logic [NSRC-1:0]    mask,
    output logic [NSRC-1:0]    pending,
    output logic [NSRC-1:0]    overrun,
    output logic               intr_req,
    output logic [CAUSE_W-1:0] intr_cause,
    input  logic               intr_ack,
    input  logic               eoi
);
    state_t              state;
    logic [CAUSE_W-1:0]  win;
    logic                win_valid;
    logic [NSRC-1:0]     ack_clr;

    intr_prio_enc #(.NSRC(NSRC), .CAUSE_W(CAUSE_W)) u_enc (
        .req   (pending & mask),
        .idx   (win),
        .valid (win_valid)
    );

    // a pulse coinciding with the ack re-arms pending without counting as overrun
    assign ack_clr = (state == REQ && intr_ack) ? (NSRC'(1) << intr_cause) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mask       <= '0;
            pending    <= '0;
            overrun    <= '0;
            intr_req   <= 1'b0;
            intr_cause <= '0;
            state      <= IDLE;
        end else begin
            if (mask_we)
                mask <= mask_wdata;
            pending <= (pending & ~ack_clr) | src_pulse;
            overrun <= (overrun & ~ack_clr) | (src_pulse & pending & ~ack_clr);
            case (state)
                IDLE: if (win_valid) begin
                    state      <= REQ;
                    intr_req   <= 1'b1;
                    intr_cause <= win;
                end
                REQ: if (intr_ack) begin
                    state    <= SERVICE;
                    intr_req <= 1'b0;
                end
                SERVICE: if (eoi)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed checks of latch, priority, commitment and reset behaviour
module tb_intr_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] src_pulse, mask_wdata, mask, pending, overrun;
    logic       mask_we, intr_req, intr_ack, eoi;
    logic [1:0] intr_cause;
    int         n_cmp = 0;
    int         n_err = 0;

    intr_ctrl dut (
        .clk(clk), .rstn(rstn), .src_pulse(src_pulse), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask), .pending(pending), .overrun(overrun),
        .intr_req(intr_req), .intr_cause(intr_cause), .intr_ack(intr_ack), .eoi(eoi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; src_pulse = '0; mask_we = 1'b0; mask_wdata = '0; intr_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        chk("rst_mask", mask, 0); chk("rst_pend", pending, 0); chk("rst_ovr", overrun, 0);
        chk("rst_req", intr_req, 0); chk("rst_cause", intr_cause, 0);

        // basic flow
        set_mask(4'b0001);
        chk("basic_mask", mask, 4'b0001);
        src_pulse = 4'b0001; tick(); src_pulse = '0;
        chk("basic_pend", pending, 4'b0001); chk("basic_req_lat", intr_req, 0);
        tick();
        chk("basic_req", intr_req, 1); chk("basic_cause", intr_cause, 0);
        tick();
        chk("basic_req_hold", intr_req, 1);
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        chk("basic_ack_req", intr_req, 0); chk("basic_ack_pend", pending, 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("basic_idle_req", intr_req, 0);

        // commitment: masking during REQ keeps the request
        src_pulse = 4'b0001; tick(); src_pulse = '0;
        tick();
        chk("commit_req", intr_req, 1);
        set_mask(4'b0000);
        chk("commit_mask", mask, 0); chk("commit_req_hold", intr_req, 1); chk("commit_cause", intr_cause, 0);
        tick();
        chk("commit_req_hold2", intr_req, 1);
        // ack/pulse collision
        intr_ack = 1'b1; src_pulse = 4'b0001; tick(); intr_ack = 1'b0; src_pulse = '0;
        chk("coll_req", intr_req, 0); chk("coll_pend", pending, 4'b0001); chk("coll_ovr", overrun, 0);
        set_mask(4'b0001);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("coll_idle", intr_req, 0);
        tick();
        chk("coll_rereq", intr_req, 1); chk("coll_cause", intr_cause, 0);
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("coll_done_pend", pending, 0);

        // priority
        set_mask(4'b1111);
        src_pulse = 4'b1010; tick(); src_pulse = '0;
        tick();
        chk("prio_req1", intr_req, 1); chk("prio_cause1", intr_cause, 1);
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        chk("prio_ack_req", intr_req, 0); chk("prio_ack_pend", pending, 4'b1000);
        tick();
        chk("prio_svc_noeoi", intr_req, 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("prio_idle", intr_req, 0);
        tick();
        chk("prio_req2", intr_req, 1); chk("prio_cause2", intr_cause, 3);
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // masked source and overrun
        set_mask(4'b0000);
        src_pulse = 4'b0100; tick(); tick(); src_pulse = '0;
        chk("ovr_pend", pending, 4'b0100); chk("ovr_flag", overrun, 4'b0100); chk("ovr_req", intr_req, 0);
        tick();
        chk("ovr_req_masked", intr_req, 0);
        set_mask(4'b0100);
        chk("ovr_old_mask_decision", intr_req, 0);
        tick();
        chk("ovr_req", intr_req, 1); chk("ovr_cause", intr_cause, 2);
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        chk("ovr_ack_pend", pending, 0); chk("ovr_ack_flag", overrun, 0);

        // reset in SERVICE, then stray handshakes
        src_pulse = 4'b0010; tick(); src_pulse = '0;
        chk("rst2_pre_pend", pending, 4'b0010);
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk("rst2_mask", mask, 0); chk("rst2_pend", pending, 0); chk("rst2_ovr", overrun, 0);
        chk("rst2_req", intr_req, 0); chk("rst2_cause", intr_cause, 0);
        eoi = 1'b1; intr_ack = 1'b1; tick(); eoi = 1'b0; intr_ack = 1'b0;
        chk("stray_req", intr_req, 0); chk("stray_pend", pending, 0);
        set_mask(4'b1000);
        src_pulse = 4'b1000; tick(); src_pulse = '0;
        tick();
        chk("post_rst_req", intr_req, 1); chk("post_rst_cause", intr_cause, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
